// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - states, opcodes, alu_op codes and mux encodings for mc_main_control
package mc_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_RESET  = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_MEM    = 3'd4;
    localparam state_t ST_WB     = 3'd5;
    localparam state_t ST_HALT   = 3'd6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SUBI  = 6'h11;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Shared with ALU_control; keep both sides in step.
    localparam logic [2:0] ALU_OP_RTYPE = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_ADD   = 3'b010;
    localparam logic [2:0] ALU_OP_ADDI  = 3'b011;
    localparam logic [2:0] ALU_OP_ANDI  = 3'b100;
    localparam logic [2:0] ALU_OP_ORI   = 3'b101;
    localparam logic [2:0] ALU_OP_SUBI  = 3'b110;
    localparam logic [2:0] ALU_OP_SLTI  = 3'b111;

    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_MEM_LD,
        CLS_MEM_ST,
        CLS_BR_EQ,
        CLS_BR_NE,
        CLS_JMP,
        CLS_IALU,
        CLS_LUI,
        CLS_ILLEGAL
    } ins_class_t;

endpackage

// File: rtl/mc_op_decode.sv
// rtl/mc_op_decode.sv - combinational opcode to instruction class, I-type alu_op and zero_ext
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [3:0] ins_class,
    output logic [2:0] imm_alu_op,
    output logic       zero_ext
);

    always_comb begin
        ins_class  = CLS_ILLEGAL;
        imm_alu_op = ALU_OP_ADD;
        zero_ext   = 1'b0;
        case (opcode)
            OP_RTYPE: ins_class = CLS_R;
            OP_LW:    ins_class = CLS_MEM_LD;
            OP_SW:    ins_class = CLS_MEM_ST;
            OP_BEQ:   ins_class = CLS_BR_EQ;
            OP_BNE:   ins_class = CLS_BR_NE;
            OP_J:     ins_class = CLS_JMP;
            OP_LUI:   ins_class = CLS_LUI;
            OP_ADDI: begin
                ins_class  = CLS_IALU;
                imm_alu_op = ALU_OP_ADDI;
            end
            OP_ANDI: begin
                ins_class  = CLS_IALU;
                imm_alu_op = ALU_OP_ANDI;
                zero_ext   = 1'b1;
            end
            OP_ORI: begin
                ins_class  = CLS_IALU;
                imm_alu_op = ALU_OP_ORI;
                zero_ext   = 1'b1;
            end
            OP_SUBI: begin
                ins_class  = CLS_IALU;
                imm_alu_op = ALU_OP_SUBI;
            end
            OP_SLTI: begin
                ins_class  = CLS_IALU;
                imm_alu_op = ALU_OP_SLTI;
            end
            default: ins_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// rtl/mc_main_control.sv - multi-cycle MIPS-subset control FSM; MC_CTRL_ILLEGAL_TRAP_EN enables HALT on illegal opcodes
module mc_main_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_write_cond_n,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       zero_ext,
    output logic       lui_sel,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       halt
);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] ins_class;
    logic [2:0] imm_alu_op;
    logic       imm_zero_ext;
    logic       zero_unused;

    // zero only qualifies the branch strobes inside the datapath.
    assign zero_unused = zero;

    mc_op_decode u_op_decode (
        .opcode     (opcode),
        .ins_class  (ins_class),
        .imm_alu_op (imm_alu_op),
        .zero_ext   (imm_zero_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (ins_class == CLS_ILLEGAL) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    state_nxt = ST_HALT;
`else
                    state_nxt = ST_FETCH;
`endif
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (ins_class)
                    CLS_R, CLS_IALU, CLS_LUI: state_nxt = ST_WB;
                    CLS_MEM_LD, CLS_MEM_ST:   state_nxt = ST_MEM;
                    default:                  state_nxt = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_nxt = (ins_class == CLS_MEM_LD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB:     state_nxt = ST_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            ST_HALT:   state_nxt = ST_HALT;
`endif
            default:   state_nxt = ST_RESET;
        endcase
    end

    always_comb begin
        pc_write        = 1'b0;
        pc_write_cond   = 1'b0;
        pc_write_cond_n = 1'b0;
        ir_write        = 1'b0;
        i_or_d          = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        reg_write       = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = SRC_B_RT;
        zero_ext        = 1'b0;
        lui_sel         = 1'b0;
        pc_source       = PC_SRC_ALU;
        alu_op          = ALU_OP_RTYPE;
        case (state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALU_OP_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = SRC_B_IMM_SH2;
                alu_op    = ALU_OP_ADD;
            end
            ST_EXEC: begin
                case (ins_class)
                    CLS_R: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRC_B_RT;
                        alu_op    = ALU_OP_RTYPE;
                    end
                    CLS_MEM_LD, CLS_MEM_ST: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ALU_OP_ADD;
                    end
                    CLS_BR_EQ, CLS_BR_NE: begin
                        alu_src_a       = 1'b1;
                        alu_src_b       = SRC_B_RT;
                        alu_op          = ALU_OP_SUB;
                        pc_source       = PC_SRC_ALUOUT;
                        pc_write_cond   = (ins_class == CLS_BR_EQ);
                        pc_write_cond_n = (ins_class == CLS_BR_NE);
                    end
                    CLS_JMP: begin
                        pc_write  = 1'b1;
                        pc_source = PC_SRC_JUMP;
                    end
                    CLS_IALU: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRC_B_IMM;
                        alu_op    = imm_alu_op;
                        zero_ext  = imm_zero_ext;
                    end
                    CLS_LUI: begin
                        alu_src_b = SRC_B_IMM;
                        lui_sel   = 1'b1;
                        alu_op    = ALU_OP_ADD;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (ins_class == CLS_MEM_LD);
                mem_write = (ins_class == CLS_MEM_ST);
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (ins_class == CLS_R);
                mem_to_reg = (ins_class == CLS_MEM_LD);
            end
            default: ;
        endcase
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign halt = (state == ST_HALT);
`else
    assign halt = 1'b0;
`endif

endmodule

// File: doc/mc_main_control.md
# mc_main_control

Multi-cycle main control unit for the MIPS-subset CPU. It sits directly upstream of `ALU_control`: it sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the datapath mux, enable and write strobes, and supplies the 3-bit `alu_op` that `ALU_control` turns into the ALU function code. It also stalls on a memory ready handshake.

## Interface
- No parameters; widths are fixed by the ISA.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instruction [31:26] from the IR; stable from DECODE onward.
- `zero`  in  1  ALU zero flag; the datapath uses it with the branch strobes.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `pc_write`, `pc_write_cond`, `pc_write_cond_n`  out  1 each  unconditional, BEQ and BNE PC enables.
- `ir_write`, `i_or_d`, `mem_read`, `mem_write`  out  1 each  IR load, address select (1 = ALUOut), memory strobes.
- `reg_write`, `reg_dst`, `mem_to_reg`  out  1 each  register-file write, rd select, MDR select.
- `alu_src_a`  out  1  0 = PC, 1 = rs.
- `alu_src_b`  out  2  00 = rt, 01 = 4, 10 = immediate, 11 = sign-extended immediate << 2.
- `zero_ext`, `lui_sel`  out  1 each  zero-extend immediate; immediate << 16.
- `pc_source`  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- `alu_op`  out  3  to `ALU_control`.
- `halt`  out  1  sticky illegal-opcode indication.

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs are a Moore decode of state plus `opcode`. Any output not listed for a state is 0.
- RESET: all outputs 0. Goes to FETCH on the first clock after `rst_n` rises.
- FETCH:
  - Drives `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=010, `pc_source`=00.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0, otherwise goes to DECODE.
- DECODE: drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=010 to compute the branch target into ALUOut, then goes to EXEC.
- Opcode decode:
  - R-type 0x00 → EXEC `alu_src_a`=1, `alu_src_b`=00, `alu_op`=000 → WB.
  - LW 0x23 / SW 0x2B → EXEC `alu_src_a`=1, `alu_src_b`=10, `alu_op`=010 → MEM.
  - BEQ 0x04 / BNE 0x05 → EXEC `alu_src_a`=1, `alu_src_b`=00, `alu_op`=001, `pc_source`=01, and `pc_write_cond` (BEQ) or `pc_write_cond_n` (BNE) → FETCH.
  - J 0x02 → EXEC `pc_write`=1, `pc_source`=10 → FETCH.
  - ADDI 0x08 / ANDI 0x0C / ORI 0x0D / SUBI 0x11 / SLTI 0x0A → EXEC `alu_src_a`=1, `alu_src_b`=10, `alu_op` = 011 / 100 / 101 / 110 / 111, `zero_ext`=1 for ANDI and ORI only → WB.
  - LUI 0x0F → EXEC `alu_src_b`=10, `lui_sel`=1, `alu_op`=010 → WB.
- MEM:
  - LW drives `mem_read`=1, `i_or_d`=1.
  - SW drives `mem_write`=1, `i_or_d`=1.
  - Holds the strobes and state until `mem_ready`=1, then LW goes to WB and SW goes to FETCH.
- WB:
  - Always drives `reg_write`=1.
  - R-type: `reg_dst`=1.
  - LW: `mem_to_reg`=1.
  - I-type and LUI: `reg_dst`=0, `mem_to_reg`=0.
  - Then goes to FETCH.
- Illegal opcode: decided in DECODE; see Configuration.

## Timing
- Cycle counts with `mem_ready` tied to 1: BEQ, BNE and J take 3 cycles; R-type, I-type, LUI and SW take 4; LW takes 5.
- Each `mem_ready`=0 cycle in FETCH or MEM adds exactly one cycle.
- Outputs change only on state change, except the `mem_ready`-qualified `ir_write` and `pc_write` in FETCH.
- A `rst_n` fall in any state forces RESET and all outputs to 0 asynchronously, including mid-MEM with strobes active.
- HALT is left only through reset.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined: an unknown opcode in DECODE goes to HALT. HALT asserts `halt`=1 and drives all other outputs 0.
- `MC_CTRL_ILLEGAL_TRAP_EN` undefined: an unknown opcode goes from DECODE to FETCH, so it executes as a 2-cycle NOP. `halt` is tied to 0 and the HALT state is not built.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - the opcode constants, including SUBI = 0x11;
  - the `alu_op` codes 000–111;
  - the `alu_src_b` and `pc_source` encodings.
- `ALU_control` uses the same `alu_op` codes.
- Sub-module `mc_op_decode` is combinational: `opcode` → instruction class (R, MEM_LD, MEM_ST, BR_EQ, BR_NE, JMP, IALU, LUI, ILLEGAL), I-type `alu_op` and `zero_ext`.

## Test plan
- Reset, then `mem_ready`=1, R-type 0x00 → RESET → FETCH → DECODE → EXEC (`alu_op`=000) → WB (`reg_write`=1, `reg_dst`=1) → FETCH; 4 cycles.
- LW 0x23 with `mem_ready` low for 2 cycles in MEM → `mem_read` and `i_or_d` held for 3 cycles, then WB with `mem_to_reg`=1; 7 cycles total.
- BNE 0x05 → EXEC shows `pc_write_cond_n`=1, `alu_op`=001, `pc_source`=01, then FETCH; 3 cycles.
- ANDI 0x0C, SLTI 0x0A, LUI 0x0F → EXEC `alu_op` = 100 / 111 / 010; `zero_ext`=1 only for ANDI; `lui_sel`=1 only for LUI.
- Opcode 0x3F: with the macro → HALT, `halt`=1 held for 10 cycles. Without the macro → FETCH on the cycle after DECODE.
- `rst_n` pulsed low mid-MEM of SW → `mem_write` drops in the same cycle; after release the unit restarts at RESET.
